// File: rtl/mips_writeback_unit.sv
// Write-port driver for the MiniMIPS 8x32 register file: merges ALU and buffered memory results, tracks pending writes.
// Optional forwarding outputs are built when MIPS_WB_FORWARD_EN is defined; otherwise they are tied to zero.
module mips_writeback_unit #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [2:0]  alu_reg,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [2:0]  mem_reg,
    input  logic [31:0] mem_data,
    input  logic        issue_valid,
    input  logic [2:0]  issue_reg,
    input  logic [2:0]  query_reg_1,
    input  logic [2:0]  query_reg_2,
    output logic        pending_1,
    output logic        pending_2,
    output logic [7:0]  pending_vec,
    output logic [31:0] write_data,
    output logic [2:0]  write_reg,
    output logic        signal_reg_write,
    output logic        fwd_hit_1,
    output logic        fwd_hit_2,
    output logic [31:0] fwd_data_1,
    output logic [31:0] fwd_data_2
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [2:0]       fifo_reg_q  [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic [7:0]       pending_q, pending_d;
    logic [2:0]       write_reg_q, write_reg_d;
    logic [31:0]      write_data_q, write_data_d;
    logic             reg_write_q, reg_write_d;

    logic             fifo_empty;
    logic             fifo_full;
    logic             force_grant;
    logic             alu_fire;
    logic             mem_push;
    logic             mem_pop;
    logic             win_valid;
    logic [2:0]       win_reg;
    logic [31:0]      win_data;
    logic             do_write;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CNT_W'(DEPTH));
    assign force_grant = (starve_q == STV_W'(STARVE_LIMIT));

    assign alu_ready = !force_grant;
    assign mem_ready = !fifo_full;

    assign alu_fire = alu_valid && !force_grant;
    assign mem_push = mem_valid && !fifo_full;
    assign mem_pop  = !fifo_empty && (force_grant || !alu_valid);

    // ALU wins unless it is idle or the FIFO has been starved long enough to force a grant.
    always_comb begin
        win_valid = 1'b0;
        win_reg   = 3'd0;
        win_data  = 32'd0;
        if (alu_fire) begin
            win_valid = 1'b1;
            win_reg   = alu_reg;
            win_data  = alu_data;
        end else if (mem_pop) begin
            win_valid = 1'b1;
            win_reg   = fifo_reg_q[rd_ptr_q];
            win_data  = fifo_data_q[rd_ptr_q];
        end
    end

    assign do_write = win_valid && (win_reg != 3'd0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        if (mem_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (mem_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({mem_push, mem_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (mem_pop) begin
            starve_d = '0;
        end else if (!fifo_empty && alu_fire) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // A set from issue overrides a clear from the same cycle's write; register 0 never pends.
    always_comb begin
        pending_d = pending_q;
        if (do_write) begin
            pending_d[win_reg] = 1'b0;
        end
        if (issue_valid) begin
            pending_d[issue_reg] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        reg_write_d  = do_write;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (do_write) begin
            write_reg_d  = win_reg;
            write_data_d = win_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_push) begin
            fifo_reg_q[wr_ptr_q]  <= mem_reg;
            fifo_data_q[wr_ptr_q] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            pending_q    <= '0;
            write_reg_q  <= 3'd0;
            write_data_q <= 32'd0;
            reg_write_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            pending_q    <= pending_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign pending_vec      = pending_q;
    assign pending_1        = pending_q[query_reg_1];
    assign pending_2        = pending_q[query_reg_2];
    assign write_reg        = write_reg_q;
    assign write_data       = write_data_q;
    assign signal_reg_write = reg_write_q;

`ifdef MIPS_WB_FORWARD_EN
    assign fwd_hit_1  = reg_write_q && (write_reg_q == query_reg_1) && (query_reg_1 != 3'd0);
    assign fwd_hit_2  = reg_write_q && (write_reg_q == query_reg_2) && (query_reg_2 != 3'd0);
    assign fwd_data_1 = write_data_q;
    assign fwd_data_2 = write_data_q;
`else
    assign fwd_hit_1  = 1'b0;
    assign fwd_hit_2  = 1'b0;
    assign fwd_data_1 = 32'd0;
    assign fwd_data_2 = 32'd0;
`endif

endmodule

// File: tb/tb_mips_writeback_unit.sv
// Self-checking bench for mips_writeback_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_mips_writeback_unit;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [2:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [2:0]  mem_reg;
    logic [31:0] mem_data;
    logic        issue_valid;
    logic [2:0]  issue_reg, query_reg_1, query_reg_2;
    logic        pending_1, pending_2;
    logic [7:0]  pending_vec;
    logic [31:0] write_data;
    logic [2:0]  write_reg;
    logic        signal_reg_write;
    logic        fwd_hit_1, fwd_hit_2;
    logic [31:0] fwd_data_1, fwd_data_2;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: FIFO as queues, starvation as a plain cycle count, scoreboard as a bit vector.
    logic [2:0]  mQReg[$];
    logic [31:0] mQData[$];
    int          mStarve;
    logic [7:0]  mPend;
    logic        mWe;
    logic [2:0]  mReg;
    logic [31:0] mData;

    mips_writeback_unit #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .query_reg_1(query_reg_1), .query_reg_2(query_reg_2),
        .pending_1(pending_1), .pending_2(pending_2), .pending_vec(pending_vec),
        .write_data(write_data), .write_reg(write_reg), .signal_reg_write(signal_reg_write),
        .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2), .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic modelReset();
        mQReg.delete();
        mQData.delete();
        mStarve = 0;
        mPend   = 8'h00;
        mWe     = 1'b0;
        mReg    = 3'd0;
        mData   = 32'd0;
    endtask

    task automatic checkComb();
        logic expHit1, expHit2;
        checkOutput("alu_ready", 32'(alu_ready), 32'(mStarve != STARVE_LIMIT));
        checkOutput("mem_ready", 32'(mem_ready), 32'(mQReg.size() < DEPTH));
        checkOutput("pending_vec", 32'(pending_vec), 32'(mPend));
        checkOutput("pending_1", 32'(pending_1), 32'(mPend[query_reg_1]));
        checkOutput("pending_2", 32'(pending_2), 32'(mPend[query_reg_2]));
`ifdef MIPS_WB_FORWARD_EN
        expHit1 = mWe && (mReg == query_reg_1) && (query_reg_1 != 3'd0);
        expHit2 = mWe && (mReg == query_reg_2) && (query_reg_2 != 3'd0);
        checkOutput("fwd_data_1", fwd_data_1, mData);
        checkOutput("fwd_data_2", fwd_data_2, mData);
`else
        expHit1 = 1'b0;
        expHit2 = 1'b0;
        checkOutput("fwd_data_1", fwd_data_1, 32'd0);
        checkOutput("fwd_data_2", fwd_data_2, 32'd0);
`endif
        checkOutput("fwd_hit_1", 32'(fwd_hit_1), 32'(expHit1));
        checkOutput("fwd_hit_2", 32'(fwd_hit_2), 32'(expHit2));
    endtask

    // Advance the model by one clock using the inputs that were stable across the edge.
    task automatic modelStep();
        logic        frc, aluTake, memTake, doPop, have;
        int          occ;
        logic [2:0]  wr;
        logic [31:0] wd;
        frc     = (mStarve == STARVE_LIMIT);
        occ     = mQReg.size();
        aluTake = alu_valid && !frc;
        memTake = mem_valid && (occ < DEPTH);
        doPop   = (occ > 0) && (frc || !alu_valid);
        have    = 1'b0;
        wr      = 3'd0;
        wd      = 32'd0;
        if (aluTake) begin
            have = 1'b1; wr = alu_reg; wd = alu_data;
        end else if (doPop) begin
            have = 1'b1; wr = mQReg[0]; wd = mQData[0];
        end
        if (doPop) begin
            void'(mQReg.pop_front());
            void'(mQData.pop_front());
            mStarve = 0;
        end else if (occ > 0 && aluTake) begin
            mStarve++;
        end
        if (memTake) begin
            mQReg.push_back(mem_reg);
            mQData.push_back(mem_data);
        end
        if (have && wr != 3'd0) begin
            mWe = 1'b1; mReg = wr; mData = wd;
            mPend[wr] = 1'b0;
        end else begin
            mWe = 1'b0;
        end
        if (issue_valid && issue_reg != 3'd0) mPend[issue_reg] = 1'b1;
    endtask

    // Drive one cycle of inputs at the falling edge, check both combinational and registered outputs.
    task automatic applyStimulus(input logic av, input logic [2:0] ar, input logic [31:0] ad,
                                 input logic mv, input logic [2:0] mr, input logic [31:0] md,
                                 input logic iv, input logic [2:0] ir,
                                 input logic [2:0] q1, input logic [2:0] q2);
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        issue_valid = iv; issue_reg = ir;
        query_reg_1 = q1; query_reg_2 = q2;
        #1;
        checkComb();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput("signal_reg_write", 32'(signal_reg_write), 32'(mWe));
        checkOutput("write_reg", 32'(write_reg), 32'(mReg));
        checkOutput("write_data", write_data, mData);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0, 3'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_reg = 3'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_reg = 3'd0; mem_data = 32'd0;
        issue_valid = 1'b0; issue_reg = 3'd0;
        query_reg_1 = 3'd0; query_reg_2 = 3'd0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_signal_reg_write", 32'(signal_reg_write), 32'd0);
        checkOutput("reset_write_reg", 32'(write_reg), 32'd0);
        checkOutput("reset_write_data", write_data, 32'd0);
        checkOutput("reset_pending_vec", 32'(pending_vec), 32'd0);
        checkOutput("reset_mem_ready", 32'(mem_ready), 32'd1);
        checkOutput("reset_alu_ready", 32'(alu_ready), 32'd1);
        rst_n = 1'b1;
        idleCycle();

        // ALU result appears one cycle later for exactly one cycle.
        applyStimulus(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0, 3'd0);
        checkOutput("alu_write_data", write_data, 32'hDEADBEEF);
        checkOutput("alu_write_reg", 32'(write_reg), 32'd3);
        checkOutput("alu_write_en", 32'(signal_reg_write), 32'd1);
        idleCycle();
        checkOutput("alu_write_one_cycle", 32'(signal_reg_write), 32'd0);

        // Fill the FIFO behind a busy ALU until starvation forces a grant.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 3'd7, 32'h7000 + 32'(i), 1'b1, 3'(i), 32'hA000 + 32'(i),
                          1'b0, 3'd0, 3'd0, 3'd0);
        end
        checkOutput("fifo_full_mem_ready", 32'(mem_ready), 32'd0);
        checkOutput("forced_alu_ready", 32'(alu_ready), 32'd0);
        applyStimulus(1'b1, 3'd7, 32'h7777, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0, 3'd0);
        checkOutput("forced_write_reg", 32'(write_reg), 32'd1);
        checkOutput("forced_write_data", write_data, 32'hA001);
        checkOutput("after_force_alu_ready", 32'(alu_ready), 32'd1);
        for (int i = 0; i < 4; i++) idleCycle();

        // Scoreboard set, clear on write, and set-beats-clear.
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd5, 3'd5, 3'd4);
        checkOutput("sb_set_5", 32'(pending_vec[5]), 32'd1);
        applyStimulus(1'b1, 3'd5, 32'h55, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd5, 3'd0);
        checkOutput("sb_clear_5", 32'(pending_vec[5]), 32'd0);
        applyStimulus(1'b1, 3'd5, 32'h56, 1'b0, 3'd0, 32'd0, 1'b1, 3'd5, 3'd5, 3'd0);
        checkOutput("sb_set_wins", 32'(pending_vec[5]), 32'd1);
        applyStimulus(1'b1, 3'd5, 32'h57, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd5, 3'd0);

        // Destination 0 is consumed silently and never pends.
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 3'd0, 3'd0, 3'd0);
        checkOutput("reg0_pending", 32'(pending_vec[0]), 32'd0);
        idleCycle();
        checkOutput("reg0_no_write", 32'(signal_reg_write), 32'd0);
        idleCycle();
        checkOutput("reg0_popped", 32'(mem_ready), 32'd1);

        // Forwarding check while the write to reg 6 is on the output stage.
        applyStimulus(1'b1, 3'd6, 32'h66666666, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0, 3'd0);
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd6, 3'd6);

        // Asynchronous reset with two FIFO entries and regs 2,3 pending.
        applyStimulus(1'b1, 3'd7, 32'h71, 1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 3'd0, 3'd0);
        applyStimulus(1'b1, 3'd6, 32'h61, 1'b1, 3'd4, 32'h44, 1'b1, 3'd3, 3'd0, 3'd0);
        checkOutput("pre_reset_pending", 32'(pending_vec), 32'h0C);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_we", 32'(signal_reg_write), 32'd0);
        checkOutput("async_reset_pending", 32'(pending_vec), 32'd0);
        checkOutput("async_reset_mem_ready", 32'(mem_ready), 32'd1);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idleCycle();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 60, 3'($urandom), $urandom,
                          $urandom_range(0, 99) < 55, 3'($urandom), $urandom,
                          $urandom_range(0, 99) < 40, 3'($urandom),
                          3'($urandom), 3'($urandom));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
